// File: rtl/scr_timing_pkg.sv
// scr_timing_pkg: timing defaults and FSM encodings shared by the SCR trigger generator and breakdown detector
package scr_timing_pkg;
  localparam logic [19:0] HALF_CYCLE_DEF   = 20'd500000;
  localparam logic [16:0] PULSE_WIDTH_DEF  = 17'd25000;
  localparam logic [16:0] SYNC_TIMEOUT_DEF = 17'd100000;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_SYNC = 3'd1;
  localparam logic [2:0] ST_FWD_PULSE = 3'd2;
  localparam logic [2:0] ST_FWD_GAP   = 3'd3;
  localparam logic [2:0] ST_NEG_PULSE = 3'd4;
  localparam logic [2:0] ST_NEG_GAP   = 3'd5;
  function automatic logic is_pulse(input logic [2:0] s);
    return s == ST_FWD_PULSE || s == ST_NEG_PULSE;
  endfunction
endpackage

// File: rtl/scr_trigger_gen_if.sv
// scr_trigger_gen_if: run control, zero-cross input and trigger outputs of the SCR trigger generator
interface scr_trigger_gen_if;
  logic        i_enable;
  logic        i_zero_cross;
  logic        o_signal_forward;
  logic        o_signal_negative;
  logic        o_signal_forbid;
  logic        o_sync_lost;
  logic        o_cycle_done;
  logic [15:0] o_cycle_count;
  modport master (
    output i_enable, i_zero_cross,
    input  o_signal_forward, o_signal_negative, o_signal_forbid, o_sync_lost, o_cycle_done, o_cycle_count
  );
  modport slave (
    input  i_enable, i_zero_cross,
    output o_signal_forward, o_signal_negative, o_signal_forbid, o_sync_lost, o_cycle_done, o_cycle_count
  );
endinterface

// File: rtl/zc_sync_edge.sv
// zc_sync_edge: two-flop synchroniser for the mains zero-cross pulse plus rising-edge detect
module zc_sync_edge (
  input  logic i_clk_50m,
  input  logic i_rst_n,
  input  logic zc_async,
  output logic zc_edge
);
  logic [2:0] sh;
  always_ff @(posedge i_clk_50m or negedge i_rst_n)
    if (!i_rst_n) sh <= '0;
    else sh <= {sh[1:0], zc_async};
  assign zc_edge = sh[1] & ~sh[2];
endmodule

// File: rtl/scr_trigger_gen.sv
// scr_trigger_gen: zero-cross synchronised forward/negative SCR trigger pulse generator
module scr_trigger_gen
  import scr_timing_pkg::*;
#(
  parameter logic [19:0] HALF_CYCLE   = HALF_CYCLE_DEF,
  parameter logic [16:0] PULSE_WIDTH  = PULSE_WIDTH_DEF,
  parameter logic [16:0] SYNC_TIMEOUT = SYNC_TIMEOUT_DEF
) (
  input logic              i_clk_50m,
  input logic              i_rst_n,
  scr_trigger_gen_if.slave bus
);
  logic        zc_edge;
  logic [2:0]  state, nxt;
  logic [19:0] phase;
  logic [16:0] wait_cnt;
  logic [15:0] cycle_count;
  logic        timeout, pulse_end, half_end, finish;
  logic        forward, negative, forbid, sync_lost, cycle_done;
  zc_sync_edge u_zc (
    .i_clk_50m (i_clk_50m),
    .i_rst_n   (i_rst_n),
    .zc_async  (bus.i_zero_cross),
    .zc_edge   (zc_edge)
  );
  assign timeout   = wait_cnt == SYNC_TIMEOUT - 17'd1;
  assign pulse_end = phase == {3'd0, PULSE_WIDTH} - 20'd1;
  assign half_end  = phase == HALF_CYCLE - 20'd1;
  assign finish    = state == ST_NEG_GAP && bus.i_enable && half_end;
  // pulses always run to completion; enable is only honoured outside them
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:      nxt = bus.i_enable ? ST_WAIT_SYNC : ST_IDLE;
      ST_WAIT_SYNC: nxt = !bus.i_enable ? ST_IDLE : (zc_edge || timeout) ? ST_FWD_PULSE : ST_WAIT_SYNC;
      ST_FWD_PULSE: nxt = !pulse_end ? ST_FWD_PULSE : bus.i_enable ? ST_FWD_GAP : ST_IDLE;
      ST_FWD_GAP:   nxt = !bus.i_enable ? ST_IDLE : half_end ? ST_NEG_PULSE : ST_FWD_GAP;
      ST_NEG_PULSE: nxt = !pulse_end ? ST_NEG_PULSE : bus.i_enable ? ST_NEG_GAP : ST_IDLE;
      ST_NEG_GAP:   nxt = !bus.i_enable ? ST_IDLE : half_end ? ST_WAIT_SYNC : ST_NEG_GAP;
      default:      nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk_50m or negedge i_rst_n)
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      phase       <= '0;
      wait_cnt    <= '0;
      cycle_count <= '0;
      forward     <= 1'b0;
      negative    <= 1'b0;
      forbid      <= 1'b1;
      sync_lost   <= 1'b0;
      cycle_done  <= 1'b0;
    end else begin
      state      <= nxt;
      phase      <= (is_pulse(nxt) && nxt != state) ? '0 : phase + 20'd1;
      wait_cnt   <= state == ST_WAIT_SYNC ? wait_cnt + 17'd1 : '0;
      forward    <= state == ST_FWD_PULSE;
      negative   <= state == ST_NEG_PULSE;
      forbid     <= state == ST_IDLE;
      cycle_done <= finish;
      if (finish) cycle_count <= cycle_count + 16'd1;
      if (state == ST_WAIT_SYNC && nxt == ST_FWD_PULSE) sync_lost <= !zc_edge;
    end
  assign bus.o_signal_forward  = forward;
  assign bus.o_signal_negative = negative;
  assign bus.o_signal_forbid   = forbid;
  assign bus.o_sync_lost       = sync_lost;
  assign bus.o_cycle_done      = cycle_done;
  assign bus.o_cycle_count     = cycle_count;
endmodule
